alarm_buzzer_seq: RTL



---
 rtl/alarm_pkg.sv | 33 +++
 rtl/alarm_buzzer_seq_if.sv | 36 +++
 rtl/alarm_prescaler.sv | 31 +++
 rtl/alarm_buzzer_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared mode encodings, sequencer states and divider helpers for the alarm buzzer sequencer.
// The SNOOZE state exists only when ALARM_SNOOZE_EN is defined.
package alarm_pkg;

    localparam logic [1:0] MODE_SILENT = 2'b00;
    localparam logic [1:0] MODE_CONT   = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;
    localparam logic [1:0] MODE_REPEAT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONT   = 3'd1,
        ST_ON     = 3'd2,
        ST_OFF    = 3'd3
`ifdef ALARM_SNOOZE_EN
        , ST_SNOOZE = 3'd4
`endif
    } state_e;

    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int half_div(input int clk_hz, input int tone_hz);
        return clk_hz / (2 * tone_hz);
    endfunction

    // Width that holds max_val without wrapping, with one bit of headroom.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/alarm_buzzer_seq_if.sv
// Command/indicator bundle between the alarm output PIO (master) and the sequencer (slave).
// The snooze line is present only when ALARM_SNOOZE_EN is defined.
interface alarm_buzzer_seq_if;

    logic [7:0] cmd;
    logic       buzzer;
    logic       led;
    logic       busy;
    logic       done;
`ifdef ALARM_SNOOZE_EN
    logic       snooze;
`endif

    modport master (
        output cmd,
`ifdef ALARM_SNOOZE_EN
        output snooze,
`endif
        input  buzzer,
        input  led,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd,
`ifdef ALARM_SNOOZE_EN
        input  snooze,
`endif
        output buzzer,
        output led,
        output busy,
        output done
    );

endinterface

// File: rtl/alarm_prescaler.sv
// Clear-able modulo-DIV counter; pulse is high while the count sits at DIV-1.
module alarm_prescaler
    import alarm_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic pulse
);

    localparam int             CNT_W = cnt_width(DIV - 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Modulo counter with synchronous clear and wrap at the terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr || (cnt_r == LAST)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign pulse = (cnt_r == LAST);

endmodule

// File: rtl/alarm_buzzer_seq.sv
// Alarm command decoder and tick-timed beep sequencer with square-wave tone output.
// Define ALARM_SNOOZE_EN to add the snooze input, SNOOZE state and SNOOZE_TICKS parameter.
module alarm_buzzer_seq
    import alarm_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int TICK_HZ      = 100,
    parameter int TONE_HZ      = 2000,
    parameter int ON_TICKS     = 20,
    parameter int OFF_TICKS    = 20
`ifdef ALARM_SNOOZE_EN
    , parameter int SNOOZE_TICKS = 500
`endif
) (
    input  logic               clk,
    input  logic               reset,
    alarm_buzzer_seq_if.slave  bus
);

    localparam int TICK_DIV = tick_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int HALF_DIV = half_div(CLK_FREQ_HZ, TONE_HZ);
    localparam int ONOFF_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
`ifdef ALARM_SNOOZE_EN
    localparam int IVL_MAX = (SNOOZE_TICKS > ONOFF_MAX) ? SNOOZE_TICKS : ONOFF_MAX;
`else
    localparam int IVL_MAX = ONOFF_MAX;
`endif
    localparam int IVL_W = cnt_width(IVL_MAX - 1);
    localparam int REM_W = cnt_width(15);

    localparam logic [IVL_W-1:0] ON_LAST  = IVL_W'(ON_TICKS - 1);
    localparam logic [IVL_W-1:0] OFF_LAST = IVL_W'(OFF_TICKS - 1);
`ifdef ALARM_SNOOZE_EN
    localparam logic [IVL_W-1:0] SNZ_LAST = IVL_W'(SNOOZE_TICKS - 1);
`endif

    logic [7:0]       cmd_q_r;
    state_e           state_r, state_s;
    logic [IVL_W-1:0] ivl_r, ivl_s;
    logic [REM_W-1:0] rem_r, rem_s;
    logic             tone_r, tone_s;
    logic             tick_s, half_s;
    logic             accept_s, tick_clr_s, tone_clr_s;
    logic             sounding_s, timed_r_s;
    logic             buzzer_s, led_s, busy_s, done_s;
    logic             buzzer_r, led_r, busy_r, done_r;

    alarm_prescaler #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr_s),
        .pulse (tick_s)
    );

    alarm_prescaler #(.DIV(HALF_DIV)) u_tone (
        .clk   (clk),
        .reset (reset),
        .clr   (tone_clr_s),
        .pulse (half_s)
    );

    // Next-state, interval/burst counters, tone phase and next output values.
    always_comb begin
        accept_s   = (bus.cmd != cmd_q_r);
        state_s    = state_r;
        rem_s      = rem_r;
        done_s     = 1'b0;
        tick_clr_s = 1'b0;

        if (accept_s) begin
            tick_clr_s = 1'b1;
            rem_s      = {REM_W{1'b0}};
            case (bus.cmd[7:6])
                MODE_SILENT: state_s = ST_IDLE;
                MODE_CONT:   state_s = ST_CONT;
                MODE_REPEAT: state_s = ST_ON;
                MODE_BURST: begin
                    if (bus.cmd[3:0] != 4'd0) begin
                        state_s = ST_ON;
                        rem_s   = REM_W'(bus.cmd[3:0]);
                    end else begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
`ifdef ALARM_SNOOZE_EN
        // A snooze (re)starts the quiet interval from a clean prescaler.
        else if (bus.snooze && (cmd_q_r[7:6] == MODE_REPEAT) &&
                 ((state_r == ST_ON) || (state_r == ST_OFF) || (state_r == ST_SNOOZE))) begin
            state_s    = ST_SNOOZE;
            tick_clr_s = 1'b1;
        end
`endif
        else begin
            case (state_r)
                ST_ON: begin
                    if (tick_s && (ivl_r == ON_LAST)) begin
                        state_s = ST_OFF;
                        if (cmd_q_r[7:6] == MODE_BURST) begin
                            rem_s = rem_r - 1'b1;
                        end else begin
                            rem_s = rem_r;
                        end
                    end else begin
                        state_s = ST_ON;
                    end
                end
                ST_OFF: begin
                    if (tick_s && (ivl_r == OFF_LAST)) begin
                        if ((cmd_q_r[7:6] == MODE_BURST) && (rem_r == {REM_W{1'b0}})) begin
                            state_s = ST_IDLE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_ON;
                        end
                    end else begin
                        state_s = ST_OFF;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (tick_s && (ivl_r == SNZ_LAST)) begin
                        state_s = ST_ON;
                    end else begin
                        state_s = ST_SNOOZE;
                    end
                end
`endif
                default: state_s = state_r;
            endcase
        end

        timed_r_s = (state_r == ST_ON) || (state_r == ST_OFF);
`ifdef ALARM_SNOOZE_EN
        timed_r_s = timed_r_s || (state_r == ST_SNOOZE);
`endif
        // Interval counter only advances inside a timed state and restarts on any change.
        if (tick_clr_s || (state_s != state_r)) begin
            ivl_s = {IVL_W{1'b0}};
        end else if (tick_s && timed_r_s) begin
            ivl_s = ivl_r + 1'b1;
        end else begin
            ivl_s = ivl_r;
        end

        sounding_s = (state_s == ST_ON) || (state_s == ST_CONT);
        tone_clr_s = accept_s || tick_clr_s || (state_s != state_r) || !sounding_s;
        if (tone_clr_s) begin
            tone_s = 1'b0;
        end else if (half_s) begin
            tone_s = ~tone_r;
        end else begin
            tone_s = tone_r;
        end

        buzzer_s = tone_s & sounding_s;
        led_s    = sounding_s;
        busy_s   = (state_s != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q_r  <= 8'h00;
            state_r  <= ST_IDLE;
            ivl_r    <= {IVL_W{1'b0}};
            rem_r    <= {REM_W{1'b0}};
            tone_r   <= 1'b0;
            buzzer_r <= 1'b0;
            led_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            cmd_q_r  <= bus.cmd;
            state_r  <= state_s;
            ivl_r    <= ivl_s;
            rem_r    <= rem_s;
            tone_r   <= tone_s;
            buzzer_r <= buzzer_s;
            led_r    <= led_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign bus.buzzer = buzzer_r;
    assign bus.led    = led_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule
